// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the multi-port register file: two read
// ports, two write ports and the background-clear handshake.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we_a;
  logic [ADDR_W-1:0] wa_a;
  logic [DATA_W-1:0] wd_a;
  logic              we_b;
  logic [ADDR_W-1:0] wa_b;
  logic [DATA_W-1:0] wd_b;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output a1, a2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, clr_req,
    input  rd1, rd2, clr_busy, clr_done
  );

  modport slave (
    input  a1, a2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, clr_req,
    output rd1, rd2, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised 2-read/2-write register file with optional hardwired zero
// entry, optional write-to-read bypass and a one-entry-per-cycle clear engine.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rf [DEPTH];

  // ptr is left at the last entry after a sweep and only rewinds on re-entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Port B is written last so it wins an address collision with port A.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (busy) begin
      rf[ptr] <= '0;
    end else begin
      if (bus.we_a && !(ZERO_REG && (bus.wa_a == '0))) begin
        rf[bus.wa_a] <= bus.wd_a;
      end
      if (bus.we_b && !(ZERO_REG && (bus.wa_b == '0))) begin
        rf[bus.wa_b] <= bus.wd_b;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = rf[a];
    if (BYPASS && !busy) begin
      if (bus.we_a && (bus.wa_a == a)) d = bus.wd_a;
      if (bus.we_b && (bus.wa_b == a)) d = bus.wd_b;
    end
    if (ZERO_REG && (a == '0)) d = '0;
    return d;
  endfunction

  assign bus.rd1      = read_port(bus.a1);
  assign bus.rd2      = read_port(bus.a2);
  assign bus.clr_busy = busy;
  assign bus.clr_done = done;
endmodule
